fmap_packer: RTL and testbench
==============================

FMAP_PACKER -- requirements
Module: fmap_packer

Interface
REQ-001 Parameter CH, default 1, number of channels per feature map.
REQ-002 Parameter IN_H, default 2, feature map height.
REQ-003 Parameter IN_W, default 2, feature map width.
REQ-004 Parameter WIDTH, default 16, element width (Q8.8 signed).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_data  input  WIDTH  signed stream element.
REQ-008 in_valid  input  1  in_data/in_last valid.
REQ-009 in_last  input  1  marks final element of a frame.
REQ-010 in_ready  output  1  block can accept an element this cycle.
REQ-011 out_vec  output  CH*IN_H*IN_W*WIDTH  packed frame for the pooling stage.
REQ-012 out_valid  output  1  out_vec holds a complete frame.
REQ-013 out_ready  input  1  downstream consumes frame.
REQ-014 frame_err  output  1  one-cycle pulse on frame-length mismatch.

Function
REQ-015 Element accepted SHALL mean in_valid=1 and in_ready=1 on a rising edge.
REQ-016 Elements SHALL arrive in order n=(ch*IN_H+h)*IN_W+w, n=0..N-1, N=CH*IN_H*IN_W; element n SHALL be stored at bits [n*WIDTH +: WIDTH].
REQ-017 Storage SHALL be two banks (ping-pong), with wr_sel, rd_sel and per-bank full flags; element counter wr_cnt width $clog2(N) (min 1).
REQ-018 in_ready SHALL equal NOT full[wr_sel], combinationally from registers only (no in_valid or out_ready dependency).
REQ-019 On acceptance with wr_cnt<N-1 and in_last=0: store element, wr_cnt+1.
REQ-020 On acceptance with wr_cnt=N-1: store element, set full[wr_sel], toggle wr_sel, wr_cnt=0; if in_last=0 pulse frame_err next cycle (frame still committed).
REQ-021 On acceptance with in_last=1 and wr_cnt<N-1: discard partial frame (bank not marked full, wr_sel unchanged), wr_cnt=0, pulse frame_err next cycle.
REQ-022 out_valid SHALL equal full[rd_sel]; out_vec SHALL equal bank[rd_sel] at all times.
REQ-023 On out_valid=1 and out_ready=1: clear full[rd_sel], toggle rd_sel.
REQ-024 Latency: frame complete at edge t -> out_valid=1 after edge t; no bubble between consecutive frames while a bank is free.
REQ-025 Simultaneous commit (bank A) and consume (bank B) in one cycle SHALL both take effect.
REQ-026 With both banks full, in_ready=0 and input SHALL stall without loss; in_ready returns 1 the cycle after a consume.
REQ-027 frame_err SHALL be registered, high exactly one cycle per error.

Reset
REQ-028 While rst=1: wr_cnt=0, wr_sel=0, rd_sel=0, full=00, both banks=0, frame_err=0; hence in_ready=1, out_valid=0, out_vec=0.
REQ-029 Reset mid-frame or with a frame pending SHALL discard all buffered data; first accepted element after release is element 0.

Structure
REQ-030 Shared package cnn_pkg SHALL hold the flat-vector width helper (CH*H*W*WIDTH) and element index function, reused by the pooling stages.
REQ-031 One sub-module fmap_bank (N-element register bank, write-enable + index, flat read port) SHALL be instantiated twice.

Verification (CH=1, IN_H=2, IN_W=2, WIDTH=16)
REQ-032 Stream 0x0100,0x0200,0x0300,0x0400 (last on 4th), out_ready=0 -> out_vec=0x0400_0300_0200_0100, out_valid=1 the cycle after 4th accept, frame_err=0.
REQ-033 Three back-to-back frames, out_ready=0 -> in_ready=0 after 2nd frame commits; raise out_ready one cycle -> frame 1 delivered, in_ready=1 next cycle, frame 3 accepted intact.
REQ-034 in_last on 2nd element -> frame_err one-cycle pulse, out_valid stays 0; next 4 elements 0xFF00,0x0080,0x0001,0xFFFF form out_vec=0xFFFF_0001_0080_FF00.
REQ-035 4 elements with in_last=0 -> frame committed, out_valid=1, frame_err one-cycle pulse.
REQ-036 Continuous in_valid=1 and out_ready=1 -> one frame every 4 cycles, in_ready never drops, frames in order.
REQ-037 Assert rst after 2 elements and with one frame pending -> out_valid=0, out_vec=0, in_ready=1 immediately; following 4-element frame delivered correctly.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared feature-map helpers (flat vector width, element index) for packer and pooling stages
package cnn_pkg;
  function automatic int flat_width(input int ch, input int h, input int w, input int width);
    return ch * h * w * width;
  endfunction
  function automatic int elem_idx(input int h, input int w, input int c, input int y, input int x);
    return (c * h + y) * w + x;
  endfunction
endpackage

// File: rtl/fmap_bank.sv
// fmap_bank: N-element register bank; clk/rst, we+idx+data write port, vec flat read port
module fmap_bank #(
  parameter int N = 4,
  parameter int WIDTH = 16,
  parameter int IW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IW-1:0]        idx,
  input  logic [WIDTH-1:0]     data,
  output logic [N*WIDTH-1:0]   vec
);
  always_ff @(posedge clk or posedge rst)
    if (rst) vec <= '0;
    else if (we) vec[idx*WIDTH +: WIDTH] <= data;
endmodule

// File: rtl/fmap_packer.sv
// fmap_packer: ping-pong frame packer; in_data/in_valid/in_last/in_ready stream in, out_vec/out_valid/out_ready frame out, frame_err length-mismatch pulse
module fmap_packer
  import cnn_pkg::*;
#(
  parameter int CH = 1,
  parameter int IN_H = 2,
  parameter int IN_W = 2,
  parameter int WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [WIDTH-1:0]             in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic [flat_width(CH,IN_H,IN_W,WIDTH)-1:0] out_vec,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                frame_err
);
  localparam int N = CH * IN_H * IN_W;
  localparam int VW = flat_width(CH, IN_H, IN_W, WIDTH);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  logic [CW-1:0] wr_cnt;
  logic wr_sel, rd_sel, acc, at_end, commit, consume;
  logic [1:0] full, set, clr;
  logic [VW-1:0] vec [2];
  assign in_ready = ~full[wr_sel];
  assign out_valid = full[rd_sel];
  assign out_vec = vec[rd_sel];
  always_comb begin
    acc = in_valid & in_ready;
    at_end = wr_cnt == CW'(N - 1);
    commit = acc & at_end;
    consume = full[rd_sel] & out_ready;
    set = commit ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
    clr = consume ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_cnt <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      full <= 2'b00;
      frame_err <= 1'b0;
    end else begin
      full <= (full | set) & ~clr;
      if (commit) wr_sel <= ~wr_sel;
      if (consume) rd_sel <= ~rd_sel;
      if (acc) wr_cnt <= (at_end | in_last) ? '0 : wr_cnt + 1'b1;
      frame_err <= acc & (at_end ^ in_last);
    end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fmap_bank #(.N(N), .WIDTH(WIDTH), .IW(CW)) u_bank (
      .clk(clk),
      .rst(rst),
      .we(acc & (wr_sel == 1'(b))),
      .idx(wr_cnt),
      .data(in_data),
      .vec(vec[b])
    );
  end
endmodule

// File: tb/tb_fmap_packer.sv
// tb_fmap_packer: directed + random checks of fmap_packer against a frame-queue reference model
module tb_fmap_packer;
  logic clk = 0, rst = 0;
  logic signed [15:0] in_data = 0;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_valid, frame_err;
  logic [63:0] out_vec;
  int errors = 0, checks = 0;
  logic [63:0] q[$];
  logic [63:0] cur = 0;
  int cnt = 0;
  logic a;
  fmap_packer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic r, output logic acc);
    logic err;
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    acc = v && (q.size() < 2);
    err = 0;
    if (q.size() > 0 && r) void'(q.pop_front());
    if (acc) begin
      cur[cnt*16 +: 16] = d;
      if (cnt == 3) begin q.push_back(cur); err = !l; cnt = 0; end
      else if (l) begin err = 1; cnt = 0; end
      else cnt++;
    end
    @(posedge clk); #1;
    chk(64'(out_valid), 64'(q.size() > 0), "out_valid");
    chk(64'(in_ready), 64'(q.size() < 2), "in_ready");
    chk(64'(frame_err), 64'(err), "frame_err");
    if (q.size() > 0) chk(out_vec, q[0], "out_vec");
  endtask
  task automatic send(input logic [15:0] d, input logic l, input logic r);
    logic acc;
    int k;
    acc = 0; k = 0;
    while (!acc && k < 20) begin step(1, d, l, r, acc); k++; end
    if (!acc) begin
      checks++; errors++;
      $error("FAIL send_timeout observed=stalled expected=accepted");
    end
  endtask
  task automatic send_frame(input logic [63:0] f, input logic r);
    for (int i = 0; i < 4; i++) send(f[i*16 +: 16], i == 3, r);
  endtask
  task automatic idle(input logic r);
    logic acc;
    step(0, 16'h0, 0, r, acc);
  endtask
  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk(64'(in_ready), 1, "rst_in_ready");
    chk(64'(out_valid), 0, "rst_out_valid");
    chk(out_vec, 0, "rst_out_vec");
    chk(64'(frame_err), 0, "rst_frame_err");
    rst = 0;
    send_frame(64'h0400_0300_0200_0100, 0);
    chk(out_vec, 64'h0400_0300_0200_0100, "basic_vec");
    chk(64'(out_valid), 1, "basic_valid");
    idle(1);
    send_frame(64'h1004_1003_1002_1001, 0);
    send_frame(64'h2004_2003_2002_2001, 0);
    chk(64'(in_ready), 0, "both_full_stall");
    step(1, 16'h3001, 0, 0, a);
    step(1, 16'h3001, 0, 1, a);
    chk(64'(in_ready), 1, "ready_after_consume");
    send_frame(64'h3004_3003_3002_3001, 0);
    chk(out_vec, 64'h2004_2003_2002_2001, "frame2_head");
    idle(1);
    chk(out_vec, 64'h3004_3003_3002_3001, "frame3_intact");
    idle(1);
    send(16'h1111, 0, 0);
    send(16'h2222, 1, 0);
    chk(64'(out_valid), 0, "short_no_valid");
    idle(0);
    send_frame(64'hFFFF_0001_0080_FF00, 0);
    chk(out_vec, 64'hFFFF_0001_0080_FF00, "after_short_vec");
    idle(1);
    for (int i = 0; i < 4; i++) send(16'h5000 + 16'(i), 0, 0);
    chk(64'(out_valid), 1, "nolast_committed");
    idle(1);
    for (int i = 0; i < 12; i++) begin
      send(16'h6000 + 16'(i), (i % 4) == 3, 1);
      chk(64'(in_ready), 1, "stream_ready");
    end
    idle(1);
    send_frame(64'h7004_7003_7002_7001, 0);
    send(16'h8001, 0, 0);
    send(16'h8002, 0, 0);
    #2 rst = 1;
    #1;
    chk(64'(out_valid), 0, "midrst_valid");
    chk(out_vec, 0, "midrst_vec");
    chk(64'(in_ready), 1, "midrst_ready");
    q.delete(); cnt = 0;
    @(posedge clk); #1 rst = 0;
    send_frame(64'h9004_9003_9002_9001, 0);
    chk(out_vec, 64'h9004_9003_9002_9001, "postrst_vec");
    for (int i = 0; i < 300; i++) begin
      logic v, l, r;
      v = $urandom_range(0, 3) != 0;
      l = (cnt == 3) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 1) == 1;
      step(v, 16'($urandom), l, r, a);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
